// File: rtl/dcache_sa_controller.sv
// N-way set-associative, write-back, write-allocate data cache controller for the MEM stage.
// Define DCACHE_PERF_CNT_EN to build the saturating hit/miss performance counters.
module dcache_sa_controller #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int LINE_W = 256,
    parameter int SETS   = 16,
    parameter int WAYS   = 2
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [ADDR_W-1:0] cpu_addr_i,
    input  logic [DATA_W-1:0] cpu_data_i,
    input  logic              cpu_MemRead_i,
    input  logic              cpu_MemWrite_i,
    output logic [DATA_W-1:0] cpu_data_o,
    output logic              cpu_stall_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [LINE_W-1:0] mem_data_o,
    output logic              mem_enable_o,
    output logic              mem_write_o,
    input  logic [LINE_W-1:0] mem_data_i,
    input  logic              mem_ack_i,
    output logic [31:0]       hit_cnt_o,
    output logic [31:0]       miss_cnt_o
);

    localparam int WORDS = LINE_W / DATA_W;
    localparam int OFF_W = $clog2(WORDS);
    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = ADDR_W - 2 - OFF_W - IDX_W;
    localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;

    localparam logic [1:0] S_IDLE      = 2'd0;
    localparam logic [1:0] S_WRITEBACK = 2'd1;
    localparam logic [1:0] S_ALLOCATE  = 2'd2;
    localparam logic [1:0] S_FILL      = 2'd3;

    typedef logic [WORDS-1:0][DATA_W-1:0] line_t;

    logic             valid_q [SETS][WAYS];
    logic             dirty_q [SETS][WAYS];
    logic [WAY_W-1:0] age_q   [SETS][WAYS];
    logic [TAG_W-1:0] tag_q   [SETS][WAYS];
    line_t            data_q  [SETS][WAYS];

    logic [1:0]       state_q, state_d;
    logic [WAY_W-1:0] victim_q, victim, hit_way;
    logic [WAY_W-1:0] oldest;
    logic             found_inv, hit, req;
    logic             idle_hit, idle_miss, store_hit, fill_ack;

    logic [TAG_W-1:0] req_tag;
    logic [IDX_W-1:0] req_idx;
    logic [OFF_W-1:0] req_off;
    logic             unused_addr_bits;

    assign req_tag          = cpu_addr_i[ADDR_W-1 -: TAG_W];
    assign req_idx          = cpu_addr_i[2+OFF_W +: IDX_W];
    assign req_off          = cpu_addr_i[2 +: OFF_W];
    assign unused_addr_bits = ^cpu_addr_i[1:0];
    assign req              = cpu_MemRead_i | cpu_MemWrite_i;

    // NOTE: every variable written in always_comb gets a default first, otherwise a latch is inferred.
    always_comb begin
        hit     = 1'b0;
        hit_way = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (valid_q[req_idx][w] && tag_q[req_idx][w] == req_tag) begin
                hit     = 1'b1;
                hit_way = WAY_W'(w);
            end
        end
    end

    // Lowest invalid way wins; otherwise the oldest way, lowest index on a tie.
    always_comb begin
        victim    = '0;
        found_inv = 1'b0;
        oldest    = age_q[req_idx][0];
        for (int w = 0; w < WAYS; w++) begin
            if (!valid_q[req_idx][w] && !found_inv) begin
                victim    = WAY_W'(w);
                found_inv = 1'b1;
            end
        end
        if (!found_inv) begin
            for (int w = 1; w < WAYS; w++) begin
                if (age_q[req_idx][w] > oldest) begin
                    oldest = age_q[req_idx][w];
                    victim = WAY_W'(w);
                end
            end
        end
    end

    assign idle_hit  = (state_q == S_IDLE) && req && hit;
    assign idle_miss = (state_q == S_IDLE) && req && !hit;
    assign store_hit = idle_hit && cpu_MemWrite_i;
    assign fill_ack  = (state_q == S_ALLOCATE) && mem_ack_i;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (idle_miss) begin
                    state_d = (valid_q[req_idx][victim] && dirty_q[req_idx][victim]) ? S_WRITEBACK
                                                                                     : S_ALLOCATE;
                end
            end
            S_WRITEBACK: if (mem_ack_i) state_d = S_ALLOCATE;
            S_ALLOCATE:  if (mem_ack_i) state_d = S_FILL;
            S_FILL:      state_d = S_IDLE;
            default:     state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state is assigned with <= so every flop samples pre-edge values.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q  <= S_IDLE;
            victim_q <= '0;
            for (int s = 0; s < SETS; s++) begin
                for (int w = 0; w < WAYS; w++) begin
                    valid_q[s][w] <= 1'b0;
                    dirty_q[s][w] <= 1'b0;
                end
            end
        end else begin
            state_q <= state_d;
            if (idle_miss) victim_q <= victim;
            if (store_hit) dirty_q[req_idx][hit_way] <= 1'b1;
            if (fill_ack) begin
                valid_q[req_idx][victim_q] <= 1'b1;
                dirty_q[req_idx][victim_q] <= 1'b0;
            end
        end
    end

    // NOTE: tag and data arrays are never reset; valid bits alone decide whether their contents matter.
    always_ff @(posedge clk_i) begin
        if (fill_ack) begin
            data_q[req_idx][victim_q] <= mem_data_i;
            tag_q[req_idx][victim_q]  <= req_tag;
        end else if (store_hit) begin
            data_q[req_idx][hit_way][req_off] <= cpu_data_i;
        end
    end

    // A freshly filled way starts as oldest so the completing hit ages every other way.
    generate
        if (WAYS > 1) begin : g_lru
            always_ff @(posedge clk_i or negedge rst_i) begin
                if (!rst_i) begin
                    for (int s = 0; s < SETS; s++) begin
                        for (int w = 0; w < WAYS; w++) age_q[s][w] <= '0;
                    end
                end else if (fill_ack) begin
                    age_q[req_idx][victim_q] <= WAY_W'(WAYS - 1);
                end else if (idle_hit) begin
                    for (int w = 0; w < WAYS; w++) begin
                        if (WAY_W'(w) == hit_way)
                            age_q[req_idx][w] <= '0;
                        else if (age_q[req_idx][w] < age_q[req_idx][hit_way])
                            age_q[req_idx][w] <= age_q[req_idx][w] + 1'b1;
                    end
                end
            end
        end else begin : g_no_lru
            always_comb begin
                for (int s = 0; s < SETS; s++) begin
                    for (int w = 0; w < WAYS; w++) age_q[s][w] = '0;
                end
            end
        end
    endgenerate

    assign cpu_stall_o  = rst_i && ((state_q != S_IDLE) || (req && !hit));
    assign cpu_data_o   = (rst_i && idle_hit) ? data_q[req_idx][hit_way][req_off] : '0;
    assign mem_enable_o = (state_q == S_WRITEBACK) || (state_q == S_ALLOCATE);
    assign mem_write_o  = (state_q == S_WRITEBACK);

    always_comb begin
        mem_addr_o = '0;
        mem_data_o = '0;
        if (state_q == S_WRITEBACK) begin
            mem_addr_o = {tag_q[req_idx][victim_q], req_idx, {(OFF_W + 2){1'b0}}};
            mem_data_o = data_q[req_idx][victim_q];
        end else if (state_q == S_ALLOCATE) begin
            mem_addr_o = {req_tag, req_idx, {(OFF_W + 2){1'b0}}};
        end
    end

`ifdef DCACHE_PERF_CNT_EN
    logic [31:0] hit_cnt_q, miss_cnt_q;
    logic        after_fill_q;

    // The hit that completes a refilled request is not a new hit.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            hit_cnt_q    <= '0;
            miss_cnt_q   <= '0;
            after_fill_q <= 1'b0;
        end else begin
            after_fill_q <= (state_q == S_FILL);
            if (idle_hit && !after_fill_q && hit_cnt_q != '1) hit_cnt_q <= hit_cnt_q + 1'b1;
            if (idle_miss && miss_cnt_q != '1) miss_cnt_q <= miss_cnt_q + 1'b1;
        end
    end

    assign hit_cnt_o  = hit_cnt_q;
    assign miss_cnt_o = miss_cnt_q;
`else
    assign hit_cnt_o  = '0;
    assign miss_cnt_o = '0;
`endif

endmodule
